// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and the coordinate type used by the
// timing generator and its animation counter.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam coord_t H_TOTAL      = 10'd800;
  localparam coord_t V_TOTAL      = 10'd525;
  localparam coord_t H_SYNC_START = 10'd656;
  localparam coord_t H_SYNC_END   = 10'd751;
  localparam coord_t V_SYNC_START = 10'd490;
  localparam coord_t V_SYNC_END   = 10'd491;

  // Inclusive window test used for both sync pulses.
  function automatic logic in_window(input coord_t c, input coord_t lo, input coord_t hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/vga_anim_counter.sv
// Frame divider and animation cel index; advances once every ANIM_DIV frames
// and wraps after ANIM_FRAMES cels.
module vga_anim_counter
#(
  parameter int ANIM_DIV    = 8,
  parameter int ANIM_FRAMES = 3
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  output logic [1:0] anim_idx
);

  localparam logic [7:0] DIV_LAST = 8'(ANIM_DIV - 1);
  localparam logic [1:0] IDX_LAST = 2'(ANIM_FRAMES - 1);

  logic [7:0] div_r;
  logic [7:0] div_nxt_s;
  logic [1:0] idx_r;
  logic [1:0] idx_nxt_s;

  // Divider and cel index next state; both only move on a frame tick.
  always_comb begin
    div_nxt_s = div_r;
    idx_nxt_s = idx_r;
    if (frame_tick) begin
      if (div_r >= DIV_LAST) begin
        div_nxt_s = 8'd0;
        if (idx_r >= IDX_LAST) begin
          idx_nxt_s = 2'd0;
        end else begin
          idx_nxt_s = idx_r + 2'd1;
        end
      end else begin
        div_nxt_s = div_r + 8'd1;
        idx_nxt_s = idx_r;
      end
    end else begin
      div_nxt_s = div_r;
      idx_nxt_s = idx_r;
    end
  end

  // Divider and cel index registers.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      div_r <= 8'd0;
      idx_r <= 2'd0;
    end else begin
      div_r <= div_nxt_s;
      idx_r <= idx_nxt_s;
    end
  end

  assign anim_idx = idx_r;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 timing generator with registered, zero-skew sync/blank.
// Define VGA_ANIM_EN to build the animation cel counter; otherwise anim_idx is 0.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE   = 640,
  parameter int V_VISIBLE   = 480,
  parameter int ANIM_DIV    = 8,
  parameter int ANIM_FRAMES = 3
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_tick,
  output logic [1:0] anim_idx
);

  localparam coord_t H_VIS_C = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C = coord_t'(V_VISIBLE);

  // An out-of-range animation configuration shows up as this named scope.
  if ((ANIM_DIV < 1) || (ANIM_DIV > 255) || (ANIM_FRAMES < 1) || (ANIM_FRAMES > 4)) begin : g_anim_cfg_out_of_range
  end

  logic   started_r;
  coord_t h_cnt_r;
  coord_t v_cnt_r;
  coord_t h_nxt_s;
  coord_t v_nxt_s;
  logic   tick_nxt_s;
  logic   hs_r;
  logic   vs_r;
  logic   blank_r;
  logic   tick_r;

  // Next raster position; the first edge after reset re-presents (0,0).
  always_comb begin
    h_nxt_s    = 10'd0;
    v_nxt_s    = 10'd0;
    tick_nxt_s = 1'b0;
    if (!started_r) begin
      h_nxt_s    = 10'd0;
      v_nxt_s    = 10'd0;
      tick_nxt_s = 1'b0;
    end else if (h_cnt_r == (H_TOTAL - 10'd1)) begin
      h_nxt_s = 10'd0;
      if (v_cnt_r == (V_TOTAL - 10'd1)) begin
        v_nxt_s    = 10'd0;
        tick_nxt_s = 1'b1;
      end else begin
        v_nxt_s    = v_cnt_r + 10'd1;
        tick_nxt_s = 1'b0;
      end
    end else begin
      h_nxt_s    = h_cnt_r + 10'd1;
      v_nxt_s    = v_cnt_r;
      tick_nxt_s = 1'b0;
    end
  end

  // Counters plus sync/blank decoded from the next position so all align.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      started_r <= 1'b0;
      h_cnt_r   <= 10'd0;
      v_cnt_r   <= 10'd0;
      hs_r      <= 1'b1;
      vs_r      <= 1'b1;
      blank_r   <= 1'b0;
      tick_r    <= 1'b0;
    end else begin
      started_r <= 1'b1;
      h_cnt_r   <= h_nxt_s;
      v_cnt_r   <= v_nxt_s;
      hs_r      <= ~in_window(h_nxt_s, H_SYNC_START, H_SYNC_END);
      vs_r      <= ~in_window(v_nxt_s, V_SYNC_START, V_SYNC_END);
      blank_r   <= (h_nxt_s < H_VIS_C) && (v_nxt_s < V_VIS_C);
      tick_r    <= tick_nxt_s;
    end
  end

  assign DrawX      = h_cnt_r;
  assign DrawY      = v_cnt_r;
  assign hs         = hs_r;
  assign vs         = vs_r;
  assign blank      = blank_r;
  assign frame_tick = tick_r;

`ifdef VGA_ANIM_EN
  vga_anim_counter #(
    .ANIM_DIV    (ANIM_DIV),
    .ANIM_FRAMES (ANIM_FRAMES)
  ) u_anim (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .frame_tick (tick_r),
    .anim_idx   (anim_idx)
  );
`else
  assign anim_idx = 2'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: table vectors plus line, frame,
// animation and mid-frame reset sequences; raster jumps use force/release.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic       hs, vs, blank, frame_tick;
  logic [9:0] DrawX, DrawY;
  logic [1:0] anim_idx;

  always #20 vga_clk = ~vga_clk;

  vga_timing_gen #(
    .H_VISIBLE   (640),
    .V_VISIBLE   (480),
    .ANIM_DIV    (2),
    .ANIM_FRAMES (3)
  ) dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .hs         (hs),
    .vs         (vs),
    .blank      (blank),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .frame_tick (frame_tick),
    .anim_idx   (anim_idx)
  );

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       tick;
  } obs_t;

  typedef struct {
    string      name;
    logic [9:0] sx;
    logic [9:0] sy;
    int         n;
    obs_t       exp;
  } vec_t;

  obs_t   sb_q[$];
  vec_t   vecs[14];
  int     checks = 0;
  int     errors = 0;
  coord_t jx, jy;
  int     mx, my;
  logic   mtick;

  function automatic obs_t mk_obs(int x, int y, logic t);
    obs_t o;
    o.x     = 10'(x);
    o.y     = 10'(y);
    o.hs    = !((x >= 656) && (x <= 751));
    o.vs    = !((y >= 490) && (y <= 491));
    o.blank = (x < 640) && (y < 480);
    o.tick  = t;
    return o;
  endfunction

  function automatic vec_t mk_vec(string nm, int sx, int sy, int n, int ex, int ey,
                                  logic ehs, logic evs, logic eb, logic et);
    vec_t v;
    v.name      = nm;
    v.sx        = 10'(sx);
    v.sy        = 10'(sy);
    v.n         = n;
    v.exp.x     = 10'(ex);
    v.exp.y     = 10'(ey);
    v.exp.hs    = ehs;
    v.exp.vs    = evs;
    v.exp.blank = eb;
    v.exp.tick  = et;
    return v;
  endfunction

  task automatic check_obs(string name, obs_t e);
    checks++;
    if (DrawX !== e.x || DrawY !== e.y || hs !== e.hs || vs !== e.vs ||
        blank !== e.blank || frame_tick !== e.tick) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b blank=%b tick=%b, expected x=%0d y=%0d hs=%b vs=%b blank=%b tick=%b",
               name, DrawX, DrawY, hs, vs, blank, frame_tick, e.x, e.y, e.hs, e.vs, e.blank, e.tick);
    end
  endtask

  task automatic check_val(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic check_reset_vals(string name);
    obs_t e;
    e.x = 10'd0; e.y = 10'd0; e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b0; e.tick = 1'b0;
    check_obs(name, e);
    check_val({name, "_anim"}, int'(anim_idx), 0);
  endtask

  // Move the raster to (x,y) between clock edges; the model follows.
  task jump_to(input int x, input int y);
    @(negedge vga_clk);
    jx = 10'(x);
    jy = 10'(y);
    force dut.h_cnt_r = jx;
    force dut.v_cnt_r = jy;
    #1;
    release dut.h_cnt_r;
    release dut.v_cnt_r;
    mx = x;
    my = y;
  endtask

  task automatic scored_cycle();
    obs_t e;
    if (mx == 799) begin
      mx = 0;
      if (my == 524) begin my = 0; mtick = 1'b1; end
      else begin my = my + 1; mtick = 1'b0; end
    end else begin
      mx = mx + 1;
      mtick = 1'b0;
    end
    sb_q.push_back(mk_obs(mx, my, mtick));
    @(posedge vga_clk);
    #1;
    e = sb_q.pop_front();
    check_obs("raster", e);
  endtask

  task automatic run_scored(int n);
    for (int i = 0; i < n; i++) scored_cycle();
  endtask

  initial begin
    #(40 * 100000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   anim_exp[7];
    int   fall_cyc[2];
    int   fall_cnt, fall_x, rise_x, bfall_x, vs_low, vs_first_x, vs_first_y, vs_rise_y;
    logic prev_hs, prev_blank, prev_vs, got_tick;
    obs_t e;

`ifdef VGA_ANIM_EN
    anim_exp = '{0, 0, 1, 1, 2, 2, 0};
`else
    anim_exp = '{0, 0, 0, 0, 0, 0, 0};
`endif
    vecs[0]  = mk_vec("blank_last_visible", 638,   0, 1, 639,   0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[1]  = mk_vec("blank_fall",         639,   0, 1, 640,   0, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[2]  = mk_vec("hs_fall",            654,  10, 2, 656,  10, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[3]  = mk_vec("hs_last_low",        750,  10, 1, 751,  10, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[4]  = mk_vec("hs_rise",            751,  10, 1, 752,  10, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[5]  = mk_vec("last_visible_line",  798, 478, 2,   0, 479, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[6]  = mk_vec("first_vblank_line",  799, 479, 1,   0, 480, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[7]  = mk_vec("vs_fall",            799, 489, 1,   0, 490, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mk_vec("vs_second_line",     799, 490, 1,   0, 491, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk_vec("vs_rise",            799, 491, 1,   0, 492, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[10] = mk_vec("hs_vs_overlap",      655, 490, 1, 656, 490, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[11] = mk_vec("frame_wrap",         798, 524, 2,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1);
    vecs[12] = mk_vec("after_wrap",           0,   0, 1,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[13] = mk_vec("mid_visible",        500, 300, 3, 503, 300, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reset hold and release
    reset_n = 1'b0;
    mtick   = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1;
    check_reset_vals("reset_hold");
    @(negedge vga_clk);
    reset_n = 1'b1;
    @(posedge vga_clk);
    #1;
    check_obs("reset_release", mk_obs(0, 0, 1'b0));
    mx = 0; my = 0;
    run_scored(5);

    // Animation cel sequence sampled in each frame_tick cycle
    for (int k = 0; k < 7; k++) begin
      jump_to(795, 524);
      got_tick = 1'b0;
      for (int c = 0; c < 10 && !got_tick; c++) begin
        @(posedge vga_clk);
        #1;
        got_tick = frame_tick;
      end
      check_val($sformatf("anim_tick_seen_%0d", k), int'(got_tick), 1);
      check_val($sformatf("anim_tick_pos_%0d", k), int'({DrawY, DrawX}), 0);
      check_val($sformatf("anim_idx_%0d", k), int'(anim_idx), anim_exp[k]);
      @(posedge vga_clk);
      #1;
      check_val($sformatf("anim_tick_width_%0d", k), int'(frame_tick), 0);
    end

    // Table vectors through the scoreboard
    for (int i = 0; i < 14; i++) begin
      jump_to(int'(vecs[i].sx), int'(vecs[i].sy));
      sb_q.push_back(vecs[i].exp);
      repeat (vecs[i].n) @(posedge vga_clk);
      #1;
      e = sb_q.pop_front();
      check_obs(vecs[i].name, e);
    end

    // Line timing over two lines
    jump_to(0, 5);
    prev_hs = 1'b1; prev_blank = 1'b1;
    fall_cnt = 0; fall_x = -1; rise_x = -1; bfall_x = -1;
    fall_cyc[0] = 0; fall_cyc[1] = 0;
    for (int c = 0; c < 1650; c++) begin
      scored_cycle();
      if (prev_hs && !hs) begin
        if (fall_cnt < 2) fall_cyc[fall_cnt] = c;
        if (fall_cnt == 0) fall_x = int'(DrawX);
        fall_cnt++;
      end
      if (!prev_hs && hs && rise_x < 0) rise_x = int'(DrawX);
      if (prev_blank && !blank && bfall_x < 0) bfall_x = int'(DrawX);
      prev_hs = hs;
      prev_blank = blank;
    end
    check_val("hs_fall_x", fall_x, 656);
    check_val("hs_rise_x", rise_x, 752);
    check_val("blank_fall_x", bfall_x, 640);
    check_val("line_period", fall_cyc[1] - fall_cyc[0], 800);

    // Vertical sync window
    jump_to(790, 489);
    prev_vs = 1'b1; vs_low = 0; vs_first_x = -1; vs_first_y = -1; vs_rise_y = -1;
    for (int c = 0; c < 1630; c++) begin
      scored_cycle();
      if (!vs) vs_low++;
      if (prev_vs && !vs && vs_first_y < 0) begin
        vs_first_x = int'(DrawX);
        vs_first_y = int'(DrawY);
      end
      if (!prev_vs && vs && vs_rise_y < 0) vs_rise_y = int'(DrawY);
      prev_vs = vs;
    end
    check_val("vs_low_cycles", vs_low, 1600);
    check_val("vs_first_x", vs_first_x, 0);
    check_val("vs_first_y", vs_first_y, 490);
    check_val("vs_rise_y", vs_rise_y, 492);

    // Frame wrap tracked cycle by cycle
    jump_to(790, 524);
    run_scored(20);

    // Asynchronous reset at (700,300) in the middle of an hsync pulse
    jump_to(690, 300);
    repeat (10) @(posedge vga_clk);
    #1;
    check_obs("pre_reset_pos", mk_obs(700, 300, 1'b0));
    #4;
    reset_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    repeat (2) @(negedge vga_clk);
    check_reset_vals("reset_held");
    reset_n = 1'b1;
    @(posedge vga_clk);
    #1;
    check_obs("restart_origin", mk_obs(0, 0, 1'b0));
    check_val("restart_anim", int'(anim_idx), 0);
    mx = 0; my = 0;
    run_scored(805);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
